// File: rtl/seg_n_sync_filt_if.sv
// Channel bundle for seg_n_sync_filt: enable, raw inputs and the filtered
// level/edge outputs. The synchroniser itself is the slave side; whatever
// drives the raw lines and consumes the filtered levels is the master side.
interface seg_n_sync_filt_if #(
    parameter int CH = 4
) ();
    logic          en;
    logic [CH-1:0] d;
    logic [CH-1:0] q;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic          any_edge;

    modport master (
        output en,
        output d,
        input  q,
        input  rise,
        input  fall,
        input  any_edge
    );

    modport slave (
        input  en,
        input  d,
        output q,
        output rise,
        output fall,
        output any_edge
    );
endinterface

// File: rtl/seg_n_sync_filt.sv
// Multi-channel N-stage synchroniser with a per-channel stability filter and
// registered one-cycle rise/fall pulses. Each channel is captured by a flop
// chain, then a new level must persist for FILT consecutive enabled cycles
// before it is accepted on q. A low enable freezes every piece of state and
// forces the edge pulses to zero.
module seg_n_sync_filt #(
    parameter int            CH      = 4,
    parameter int            STAGES  = 2,
    parameter int            FILT    = 3,
    parameter logic [CH-1:0] RST_VAL = {CH{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    seg_n_sync_filt_if.slave  bus
);

    // A FILT of 1 still needs a one-bit counter so the arrays stay legal;
    // with CNT_MAX = 0 it never leaves zero.
    localparam int            CW      = (FILT > 1) ? $clog2(FILT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILT - 1);

    logic [CH-1:0] r_sync [STAGES];
    logic [CH-1:0] r_q;
    logic [CH-1:0] r_rise;
    logic [CH-1:0] r_fall;
    logic [CW-1:0] r_cnt  [CH];

    logic [CH-1:0] w_sync;
    logic [CH-1:0] w_q_nxt;
    logic [CH-1:0] w_rise_nxt;
    logic [CH-1:0] w_fall_nxt;
    logic [CW-1:0] w_cnt_nxt [CH];

    // Last stage of the chain is the metastability-safe view of d.
    assign w_sync = r_sync[STAGES-1];

    // Per-channel filter decision: count consecutive mismatches, accept the
    // new level on the FILT-th one, and flag the accepted direction.
    always_comb begin
        w_q_nxt    = r_q;
        w_rise_nxt = {CH{1'b0}};
        w_fall_nxt = {CH{1'b0}};
        for (int i = 0; i < CH; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (bus.en) begin
                if (w_sync[i] == r_q[i]) begin
                    // Any return to agreement abandons a partial count.
                    w_cnt_nxt[i] = {CW{1'b0}};
                end else if (r_cnt[i] == CNT_MAX) begin
                    w_q_nxt[i]    = w_sync[i];
                    w_cnt_nxt[i]  = {CW{1'b0}};
                    w_rise_nxt[i] = w_sync[i];
                    w_fall_nxt[i] = ~w_sync[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CW'(1'b1);
                end
            end else begin
                w_cnt_nxt[i] = r_cnt[i];
            end
        end
    end

    // Synchroniser chain: shifts only on enabled edges, reset beats enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                r_sync[k] <= RST_VAL;
            end
        end else if (bus.en) begin
            r_sync[0] <= bus.d;
            for (int k = 1; k < STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                r_sync[k] <= r_sync[k];
            end
        end
    end

    // Filter state and edge pulses; pulses are recomputed every edge so they
    // can never outlast one cycle, and reset never produces a pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q    <= RST_VAL;
            r_rise <= {CH{1'b0}};
            r_fall <= {CH{1'b0}};
            for (int i = 0; i < CH; i++) begin
                r_cnt[i] <= {CW{1'b0}};
            end
        end else begin
            r_q    <= w_q_nxt;
            r_rise <= w_rise_nxt;
            r_fall <= w_fall_nxt;
            for (int i = 0; i < CH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    assign bus.q        = r_q;
    assign bus.rise     = r_rise;
    assign bus.fall     = r_fall;
    assign bus.any_edge = |(r_rise | r_fall);

endmodule

// File: tb/tb_seg_n_sync_filt.sv
// Bench for seg_n_sync_filt. Two instances: the default configuration
// (STAGES=2, FILT=3, reset value 0) and a short configuration (STAGES=3,
// FILT=1, reset value 4'h4). Each scenario is a table of per-edge inputs
// with hand-derived expected outputs; the expectation is queued when the
// inputs are driven and popped after the edge that should produce it.
module tb_seg_n_sync_filt;

    typedef struct packed {
        logic       rst;
        logic       en;
        logic [3:0] d;
        logic [3:0] q;
        logic [3:0] rise;
        logic [3:0] fall;
    } vec_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_pass  = 0;
    int   n_total = 0;
    vec_t sb [$];

    seg_n_sync_filt_if #(.CH(4)) bus_a ();
    seg_n_sync_filt_if #(.CH(4)) bus_b ();

    seg_n_sync_filt #(.CH(4), .STAGES(2), .FILT(3), .RST_VAL(4'h0)) u_dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a)
    );

    seg_n_sync_filt #(.CH(4), .STAGES(3), .FILT(1), .RST_VAL(4'h4)) u_dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    function automatic vec_t row(input logic r, input logic e, input logic [3:0] d,
                                 input logic [3:0] q, input logic [3:0] ri, input logic [3:0] fa);
        vec_t v;
        v.rst = r; v.en = e; v.d = d; v.q = q; v.rise = ri; v.fall = fa;
        return v;
    endfunction

    task automatic test_reset();
        vec_t tbl [5];
        vec_t e;
        tbl = '{row(1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0),
                row(1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0)};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            rst_a = tbl[k].rst; bus_a.en = tbl[k].en; bus_a.d = tbl[k].d;
            sb.push_back(tbl[k]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_total++;
            if ({bus_a.q, bus_a.rise, bus_a.fall, bus_a.any_edge} !== {e.q, e.rise, e.fall, |(e.rise | e.fall)})
                $display("FAIL reset[%0d]: got q=%h rise=%h fall=%h any=%b, want q=%h rise=%h fall=%h any=%b",
                         k, bus_a.q, bus_a.rise, bus_a.fall, bus_a.any_edge, e.q, e.rise, e.fall, |(e.rise | e.fall));
            else n_pass++;
        end
    endtask

    task automatic test_step();
        vec_t tbl [13];
        vec_t e;
        tbl = '{row(1'b0, 1'b1, 4'h5, 4'h0, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h5, 4'h0, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h5, 4'h0, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h5, 4'h0, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h5, 4'h5, 4'h5, 4'h0),
                row(1'b0, 1'b1, 4'h5, 4'h5, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h5, 4'h5, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h0, 4'h5, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h0, 4'h5, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h0, 4'h5, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h0, 4'h5, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h5),
                row(1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0)};
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            rst_a = tbl[k].rst; bus_a.en = tbl[k].en; bus_a.d = tbl[k].d;
            sb.push_back(tbl[k]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_total++;
            if ({bus_a.q, bus_a.rise, bus_a.fall, bus_a.any_edge} !== {e.q, e.rise, e.fall, |(e.rise | e.fall)})
                $display("FAIL step[%0d]: got q=%h rise=%h fall=%h any=%b, want q=%h rise=%h fall=%h any=%b",
                         k, bus_a.q, bus_a.rise, bus_a.fall, bus_a.any_edge, e.q, e.rise, e.fall, |(e.rise | e.fall));
            else n_pass++;
        end
    endtask

    task automatic test_glitch();
        vec_t tbl [18];
        vec_t e;
        tbl = '{row(1'b0, 1'b1, 4'h1, 4'h0, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h1, 4'h0, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h1, 4'h0, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h1, 4'h0, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h1, 4'h0, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h1, 4'h0, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h1, 4'h1, 4'h1, 4'h0),
                row(1'b0, 1'b1, 4'h1, 4'h1, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h0, 4'h1, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h0, 4'h1, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h0, 4'h1, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h0, 4'h1, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h1),
                row(1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0)};
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            rst_a = tbl[k].rst; bus_a.en = tbl[k].en; bus_a.d = tbl[k].d;
            sb.push_back(tbl[k]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_total++;
            if ({bus_a.q, bus_a.rise, bus_a.fall, bus_a.any_edge} !== {e.q, e.rise, e.fall, |(e.rise | e.fall)})
                $display("FAIL glitch[%0d]: got q=%h rise=%h fall=%h any=%b, want q=%h rise=%h fall=%h any=%b",
                         k, bus_a.q, bus_a.rise, bus_a.fall, bus_a.any_edge, e.q, e.rise, e.fall, |(e.rise | e.fall));
            else n_pass++;
        end
    endtask

    task automatic test_enable();
        vec_t tbl [16];
        vec_t e;
        tbl = '{row(1'b0, 1'b1, 4'h1, 4'h0, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h1, 4'h0, 4'h0, 4'h0),
                row(1'b0, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0),
                row(1'b0, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0),
                row(1'b0, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h1, 4'h0, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h1, 4'h0, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h1, 4'h1, 4'h1, 4'h0),
                row(1'b0, 1'b0, 4'h1, 4'h1, 4'h0, 4'h0),
                row(1'b0, 1'b0, 4'h0, 4'h1, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h0, 4'h1, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h0, 4'h1, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h0, 4'h1, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h0, 4'h1, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h1),
                row(1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0)};
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            rst_a = tbl[k].rst; bus_a.en = tbl[k].en; bus_a.d = tbl[k].d;
            sb.push_back(tbl[k]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_total++;
            if ({bus_a.q, bus_a.rise, bus_a.fall, bus_a.any_edge} !== {e.q, e.rise, e.fall, |(e.rise | e.fall)})
                $display("FAIL enable[%0d]: got q=%h rise=%h fall=%h any=%b, want q=%h rise=%h fall=%h any=%b",
                         k, bus_a.q, bus_a.rise, bus_a.fall, bus_a.any_edge, e.q, e.rise, e.fall, |(e.rise | e.fall));
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        vec_t tbl [10];
        vec_t e;
        tbl = '{row(1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0),
                row(1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'hF, 4'hF, 4'hF, 4'h0),
                row(1'b0, 1'b1, 4'hF, 4'hF, 4'h0, 4'h0)};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            rst_a = tbl[k].rst; bus_a.en = tbl[k].en; bus_a.d = tbl[k].d;
            sb.push_back(tbl[k]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_total++;
            if ({bus_a.q, bus_a.rise, bus_a.fall, bus_a.any_edge} !== {e.q, e.rise, e.fall, |(e.rise | e.fall)})
                $display("FAIL reset_mid[%0d]: got q=%h rise=%h fall=%h any=%b, want q=%h rise=%h fall=%h any=%b",
                         k, bus_a.q, bus_a.rise, bus_a.fall, bus_a.any_edge, e.q, e.rise, e.fall, |(e.rise | e.fall));
            else n_pass++;
        end
    endtask

    task automatic test_short_cfg();
        vec_t tbl [8];
        vec_t e;
        tbl = '{row(1'b1, 1'b1, 4'h4, 4'h4, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h4, 4'h4, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h4, 4'h4, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h2, 4'h4, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h2, 4'h4, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h2, 4'h4, 4'h0, 4'h0),
                row(1'b0, 1'b1, 4'h2, 4'h2, 4'h2, 4'h4),
                row(1'b0, 1'b1, 4'h2, 4'h2, 4'h0, 4'h0)};
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            rst_b = tbl[k].rst; bus_b.en = tbl[k].en; bus_b.d = tbl[k].d;
            sb.push_back(tbl[k]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_total++;
            if ({bus_b.q, bus_b.rise, bus_b.fall, bus_b.any_edge} !== {e.q, e.rise, e.fall, |(e.rise | e.fall)})
                $display("FAIL short_cfg[%0d]: got q=%h rise=%h fall=%h any=%b, want q=%h rise=%h fall=%h any=%b",
                         k, bus_b.q, bus_b.rise, bus_b.fall, bus_b.any_edge, e.q, e.rise, e.fall, |(e.rise | e.fall));
            else n_pass++;
        end
    endtask

    initial begin
        rst_a    = 1'b1;
        bus_a.en = 1'b1;
        bus_a.d  = 4'h0;
        rst_b    = 1'b1;
        bus_b.en = 1'b1;
        bus_b.d  = 4'h4;
        test_reset();
        test_step();
        test_glitch();
        test_enable();
        test_reset_mid();
        test_short_cfg();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
